// File: rtl/datapath_alu.sv
// 32-bit datapath ALU. Logic/add/sub finish in one clock; signed MUL and DIV
// run a fixed 33-cycle iterative sequence on operand magnitudes and write
// the 64-bit result to the Hi/Lo pair. start/busy/done handshake to control.
module datapath_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    output logic [WIDTH-1:0] Result,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Zero,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_NOT = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_DIV = 4'b0110;

    localparam int              CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    // visible outputs
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             zero_q, busy_q, done_q;

    // iterative engine state
    logic             is_div_q;   // 1 = divide, 0 = multiply
    logic             neg_lo_q;   // product / quotient must be negated
    logic             neg_hi_q;   // remainder must be negated (dividend < 0)
    logic             div0_q;     // divisor was zero
    logic [WIDTH-1:0] a_q;        // raw dividend, returned in Hi on divide-by-zero
    logic [WIDTH-1:0] mag_b_q;    // |multiplicand| for MUL, |divisor| for DIV
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0]   alu_d;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_top;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fin_hi, fin_lo;
    logic               is_long;

    assign mag_a   = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign mag_b   = B[WIDTH-1] ? (~B + 1'b1) : B;
    assign is_long = (Op == OP_MUL) || (Op == OP_DIV);

    // Shift-add multiply: add the multiplicand into the upper half when the
    // current multiplier bit (acc LSB) is set, then shift the pair right.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                     {1'b0, (acc_q[0] ? mag_b_q : {WIDTH{1'b0}})};

    // Restoring divide: partial remainder shifted left with the next dividend
    // bit; the extra top bit keeps the compare exact for large divisors.
    assign div_top = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge  = (div_top >= {1'b0, mag_b_q});

    // Single-cycle operation result
    always_comb begin
        alu_d = '0;
        case (Op)
            OP_AND:  alu_d = A & B;
            OP_OR:   alu_d = A | B;
            OP_NOT:  alu_d = ~A;
            OP_ADD:  alu_d = A + B;
            OP_SUB:  alu_d = A - B;
            default: alu_d = '0;
        endcase
    end

    // One iteration of the multiply or divide engine
    always_comb begin
        acc_d = acc_q;
        if (is_div_q) begin
            acc_d[2*WIDTH-1:WIDTH] = div_ge ? (div_top[WIDTH-1:0] - mag_b_q)
                                            : div_top[WIDTH-1:0];
            acc_d[WIDTH-1:0]       = {acc_q[WIDTH-2:0], div_ge};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign correction and special cases applied on the completion cycle.
    // -2^31 / -1 needs no special handling: the magnitude quotient 2^31 is
    // left un-negated and reads back as 32'h80000000 with remainder 0.
    always_comb begin
        prod_s = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
        quo    = acc_q[WIDTH-1:0];
        rem    = acc_q[2*WIDTH-1:WIDTH];
        fin_lo = prod_s[WIDTH-1:0];
        fin_hi = prod_s[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            if (div0_q) begin
                fin_lo = '1;
                fin_hi = a_q;
            end else begin
                fin_lo = neg_lo_q ? (~quo + 1'b1) : quo;
                fin_hi = neg_hi_q ? (~rem + 1'b1) : rem;
            end
        end
    end

    // Handshake, operand capture, iteration count and output registers.
    // A start landing in the done cycle is dropped so done stays a single pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            a_q      <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                if (cnt_q == LAST) begin
                    hi_q     <= fin_hi;
                    lo_q     <= fin_lo;
                    result_q <= fin_lo;
                    zero_q   <= (fin_lo == '0);
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                end else begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (start && !done_q) begin
                if (is_long) begin
                    busy_q   <= 1'b1;
                    cnt_q    <= '0;
                    is_div_q <= (Op == OP_DIV);
                    a_q      <= A;
                    neg_lo_q <= A[WIDTH-1] ^ B[WIDTH-1];
                    neg_hi_q <= A[WIDTH-1];
                    div0_q   <= (B == '0);
                    if (Op == OP_DIV) begin
                        mag_b_q <= mag_b;
                        acc_q   <= {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        mag_b_q <= mag_a;
                        acc_q   <= {{WIDTH{1'b0}}, mag_b};
                    end
                end else begin
                    result_q <= alu_d;
                    zero_q   <= (alu_d == '0);
                    done_q   <= 1'b1;
                end
            end
        end
    end

    assign Result = result_q;
    assign Hi     = hi_q;
    assign Lo     = lo_q;
    assign Zero   = zero_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_datapath_alu.sv
// Bench for datapath_alu: transaction-level reference model compared against
// every output on every cycle, plus directed literal checks of known results.
module tb_datapath_alu;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] A, B;
    logic [3:0]  Op;
    logic [31:0] Result, Hi, Lo;
    logic        Zero, busy, done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 0;

    datapath_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B), .Op(Op),
        .Result(Result), .Hi(Hi), .Lo(Lo), .Zero(Zero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // reference arithmetic straight from the operation table
    function automatic void ref_op(input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] op, output logic [31:0] r,
                                   output logic [31:0] h, output logic [31:0] l);
        longint sa, sb, p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        r = 0; h = 0; l = 0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = ~a;
            4'd3: r = a + b;
            4'd4: r = a - b;
            4'd5: begin p = sa * sb; h = p[63:32]; l = p[31:0]; r = l; end
            4'd6: begin
                if (b == 0) begin l = 32'hFFFFFFFF; h = a; end
                else begin l = 32'(sa / sb); h = 32'(sa % sb); end
                r = l;
            end
            default: r = 0;
        endcase
    endfunction

    // model: what the outputs must be after each rising edge
    logic [31:0] m_result = 0, m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    bit          m_zero = 1, m_busy = 0, m_done = 0, pend = 0;
    int          pend_due = 0;

    always @(posedge clk) begin
        bit take;
        logic [31:0] r, h, l;
        cyc++;
        if (reset) begin
            m_result = 0; m_hi = 0; m_lo = 0; m_zero = 1;
            m_busy = 0; m_done = 0; pend = 0;
        end else begin
            take = start && !m_busy && !m_done;
            m_done = 0;
            if (pend && cyc == pend_due) begin
                m_hi = p_hi; m_lo = p_lo; m_result = p_lo; m_zero = (p_lo == 0);
                m_busy = 0; m_done = 1; pend = 0;
            end else if (take) begin
                ref_op(A, B, Op, r, h, l);
                if (Op == 4'd5 || Op == 4'd6) begin
                    pend = 1; pend_due = cyc + 33; p_hi = h; p_lo = l; m_busy = 1;
                end else begin
                    m_result = r; m_zero = (r == 0); m_done = 1;
                end
            end
        end
    end

    // compare every output against the model, away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            chk("cyc Result", Result, m_result);
            chk("cyc Hi",     Hi,     m_hi);
            chk("cyc Lo",     Lo,     m_lo);
            chk("cyc Zero",   Zero,   m_zero);
            chk("cyc busy",   busy,   m_busy);
            chk("cyc done",   done,   m_done);
        end
    end

    // noise: 0 none, 1 random extra starts while busy, 2 start held while busy
    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input int noise, output int lat);
        @(posedge clk); #2;
        A = a; B = b; Op = op; start = 1;
        @(posedge clk); #2;
        start = 0; A = $urandom; B = $urandom; Op = 4'($urandom);
        lat = 0;
        while (!done) begin
            if (lat > 60) begin
                checks++; errors++;
                $display("FAIL done_wait: no done after %0d cycles, required within 33", lat);
                break;
            end
            if (busy && (noise == 2 || (noise == 1 && $urandom_range(0, 5) == 0))) begin
                start = 1; A = $urandom; B = $urandom; Op = 4'($urandom_range(0, 15));
            end
            @(posedge clk); #2;
            start = 0;
            lat++;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h1;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, dn;
        logic [3:0] op;
        reset = 1; start = 0; A = 0; B = 0; Op = 0;
        @(posedge clk); #2; mon_en = 1;
        @(posedge clk); #2; reset = 0;

        chk("reset Result", Result, 32'h0);
        chk("reset Hi", Hi, 32'h0);
        chk("reset Lo", Lo, 32'h0);
        chk("reset Zero", Zero, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);

        run(32'hA5A5A5A5, 32'h5A5A5A5A, 4'd0, 0, lat);
        chk("AND Result", Result, 32'h00000000); chk("AND Zero", Zero, 1'b1); chk("AND lat", lat, 0);
        run(32'hA5A5A5A5, 32'h5A5A5A5A, 4'd1, 0, lat);
        chk("OR Result", Result, 32'hFFFFFFFF); chk("OR lat", lat, 0);
        run(32'hA5A5A5A5, 32'h5A5A5A5A, 4'd2, 0, lat);
        chk("NOT Result", Result, 32'h5A5A5A5A);
        run(32'hA5A5A5A5, 32'h5A5A5A5A, 4'd3, 0, lat);
        chk("ADD Result", Result, 32'hFFFFFFFF); chk("ADD Zero", Zero, 1'b0);
        run(32'hA5A5A5A5, 32'h5A5A5A5A, 4'd4, 0, lat);
        chk("SUB Result", Result, 32'h4B4B4B4B);
        run(32'd5, 32'd5, 4'd4, 0, lat);
        chk("SUB0 Result", Result, 32'h0); chk("SUB0 Zero", Zero, 1'b1);
        run(32'h12345678, 32'h1, 4'd9, 0, lat);
        chk("reserved Result", Result, 32'h0);

        run(32'd3, 32'hFFFFFFFE, 4'd5, 0, lat);
        chk("MUL lat", lat, 33);
        chk("MUL Hi", Hi, 32'hFFFFFFFF); chk("MUL Lo", Lo, 32'hFFFFFFFA);
        chk("MUL Result", Result, 32'hFFFFFFFA);
        chk("model MUL Lo", m_lo, 32'hFFFFFFFA);
        run(32'hA5A5A5A5, 32'h5A5A5A5A, 4'd1, 0, lat);
        chk("hold Hi", Hi, 32'hFFFFFFFF); chk("hold Lo", Lo, 32'hFFFFFFFA);
        run(32'h7FFFFFFF, 32'h7FFFFFFF, 4'd5, 0, lat);
        chk("MULmax Hi", Hi, 32'h3FFFFFFF); chk("MULmax Lo", Lo, 32'h00000001);

        run(32'd7, 32'hFFFFFFFE, 4'd6, 0, lat);
        chk("DIV lat", lat, 33);
        chk("DIV Lo", Lo, 32'hFFFFFFFD); chk("DIV Hi", Hi, 32'h00000001);
        run(32'hFFFFFFF9, 32'd2, 4'd6, 0, lat);
        chk("DIVn Lo", Lo, 32'hFFFFFFFD); chk("DIVn Hi", Hi, 32'hFFFFFFFF);
        chk("model DIVn Hi", m_hi, 32'hFFFFFFFF);
        run(32'h12345678, 32'd0, 4'd6, 0, lat);
        chk("DIV0 Lo", Lo, 32'hFFFFFFFF); chk("DIV0 Hi", Hi, 32'h12345678);
        chk("DIV0 lat", lat, 33);
        run(32'h80000000, 32'hFFFFFFFF, 4'd6, 0, lat);
        chk("DIVovf Lo", Lo, 32'h80000000); chk("DIVovf Hi", Hi, 32'h0);

        // starts held high throughout the busy window must all be ignored
        run(32'd3, 32'hFFFFFFFE, 4'd5, 2, lat);
        chk("busy-start lat", lat, 33);
        chk("busy-start Hi", Hi, 32'hFFFFFFFF); chk("busy-start Lo", Lo, 32'hFFFFFFFA);

        // reset in the middle of a multiply
        @(posedge clk); #2;
        A = 32'd3; B = 32'hFFFFFFFE; Op = 4'd5; start = 1;
        @(posedge clk); #2; start = 0;
        repeat (9) @(posedge clk);
        #2; reset = 1;
        @(posedge clk); #2; reset = 0;
        chk("midreset Result", Result, 32'h0);
        chk("midreset Hi", Hi, 32'h0); chk("midreset Lo", Lo, 32'h0);
        chk("midreset Zero", Zero, 1'b1); chk("midreset busy", busy, 1'b0);
        dn = 0;
        repeat (40) begin @(posedge clk); #2; if (done) dn++; end
        chk("midreset no done", dn, 0);
        run(32'h7FFFFFFF, 32'h7FFFFFFF, 4'd5, 0, lat);
        chk("post-reset Hi", Hi, 32'h3FFFFFFF); chk("post-reset Lo", Lo, 32'h00000001);

        // random traffic, checked cycle by cycle against the model
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: op = 4'd5;
                3, 4, 5: op = 4'd6;
                default: op = 4'($urandom_range(0, 15));
            endcase
            run(pick(), pick(), op, 1, lat);
        end

        repeat (3) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/datapath_alu.md
Name: datapath_alu

Overview:
32-bit integer ALU for the CPU datapath. Performs AND, OR, NOT, ADD, SUB in one clock and signed MUL and DIV iteratively. The 64-bit MUL/DIV results go to the Hi/Lo register pair. A start/busy/done handshake sequences the block from the control unit. It has one clock and a synchronous, active-high reset.

Parameters:
WIDTH, 32, operand/result width; only 32 is required to be supported.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous active-high reset
start  input  1  one-cycle request; A, B, Op sampled when start=1 and busy=0
A  input  32  operand A (multiplicand / dividend)
B  input  32  operand B (multiplier / divisor)
Op  input  4  operation select
Result  output  32  registered main result
Hi  output  32  MUL high word / DIV remainder
Lo  output  32  MUL low word / DIV quotient
Zero  output  1  registered, 1 when the last written Result == 0
busy  output  1  high while a MUL/DIV is in progress
done  output  1  one-cycle pulse when outputs update

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: Result=0, Hi=0, Lo=0, Zero=1, busy=0, done=0. Any MUL/DIV in progress is aborted and no done is issued.
- Op encoding:
  - 0000 AND: A&B
  - 0001 OR: A|B
  - 0010 NOT: ~A, B ignored
  - 0011 ADD: A+B mod 2^32, carry discarded
  - 0100 SUB: A-B mod 2^32
  - 0101 MUL: signed A*B
  - 0110 DIV: signed A/B
  - 0111-1111 reserved: Result=0
- Single-cycle ops (0000-0100, reserved): start accepted at edge N. At the same edge N, Result and Zero are written and done=1 for the following cycle. Hi and Lo are unchanged. busy stays 0.
- MUL: two's-complement 64-bit product {Hi,Lo}. Iterative (shift-add on magnitudes plus sign fix, or Booth).
- DIV: quotient in Lo, remainder in Hi. Truncates toward zero; remainder takes the sign of the dividend. Iterative restoring or non-restoring.
- MUL/DIV timing:
  - start accepted at edge N; operands are latched internally.
  - busy=1 from edge N through edge N+32.
  - At edge N+33: Hi and Lo are written, Result=Lo, Zero=(Lo==0), busy drops to 0, done=1 for one cycle.
  - Fixed latency of 33 cycles, independent of the data.
- Divide by zero (B=0): completes with the normal latency; Lo=32'hFFFFFFFF, Hi=A.
- Overflow case (-2^31 / -1): Lo=32'h80000000, Hi=0.
- start while busy=1 is ignored; the operation in progress is unaffected.
- Inputs A, B, Op may change after acceptance without effect.
- Outputs hold their last value until the next completion or reset.
- done is never high for two consecutive cycles.
- reset asserted in the same cycle as start: reset wins and start is ignored.

Test Plan:
- Logic ops, A=A5A5A5A5, B=5A5A5A5A, start pulsed for each Op:
  - AND -> Result=00000000, Zero=1
  - OR -> FFFFFFFF
  - NOT -> 5A5A5A5A
  - done one cycle after start each time.
- Arithmetic, same operands: ADD -> FFFFFFFF, Zero=0; SUB -> 4B4B4B4B. With A=5, B=5, SUB -> Result=0, Zero=1.
- MUL signed, A=3, B=FFFFFFFE (-2):
  - busy for 33 cycles, then Hi=FFFFFFFF, Lo=FFFFFFFA, done pulse.
  - A=7FFFFFFF, B=7FFFFFFF -> Hi=3FFFFFFF, Lo=00000001.
- DIV signed:
  - A=7, B=FFFFFFFE -> Lo=FFFFFFFD, Hi=00000001.
  - A=FFFFFFF9 (-7), B=2 -> Lo=FFFFFFFD, Hi=FFFFFFFF.
  - B=0 -> Lo=FFFFFFFF, Hi=A.
- Handshake: a second start while busy is ignored and the first result is intact. Single-cycle ops leave Hi and Lo unchanged.
- Reset: assert reset at cycle 10 of a MUL -> all outputs reset, busy=0, no done. A fresh op afterwards completes correctly.
